// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants for the UART receive FIFO.
// Entry word layout, timeout FSM encoding, default sizes.
package uart_rx_pkg;

  localparam int RX_DEPTH_DEF   = 16;
  localparam int RX_AW_DEF      = 4;
  localparam int RX_IRQ_DEF     = 8;
  localparam int RX_TIMEOUT_DEF = 640;

  localparam int ENTRY_W  = 10;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 8;
  localparam int PAR_BIT  = 8;
  localparam int FRM_BIT  = 9;

  typedef logic [ENTRY_W-1:0] rx_word_t;

  typedef struct packed {
    logic       frm;
    logic       par;
    logic [7:0] data;
  } rx_entry_t;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_COUNTING = 1'b1;

  function automatic rx_word_t rx_pack(
    input logic [7:0] d,
    input logic       p,
    input logic       f
  );
    rx_word_t w;
    w = '0;
    w[DATA_LSB +: DATA_W] = d;
    w[PAR_BIT] = p;
    w[FRM_BIT] = f;
    return w;
  endfunction

  function automatic rx_entry_t rx_unpack(input rx_word_t w);
    rx_entry_t e;
    e.data = w[DATA_LSB +: DATA_W];
    e.par  = w[PAR_BIT];
    e.frm  = w[FRM_BIT];
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_timeout.sv
// uart_rx_fifo_timeout: inactivity timer for the RX FIFO.
// Counts baud ticks while data sits unread; raises sticky timeout.
module uart_rx_fifo_timeout
  import uart_rx_pkg::*;
#(
  parameter int TIMEOUT_TICKS = RX_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic baud_clock,
  input  logic empty,
  input  logic write_accepted,
  input  logic read_accepted,
  output logic rx_timeout
);

  localparam int CW =
    (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_TICKS - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;

  // FSM, tick counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
          if (!empty)
            r_state <= ST_COUNTING;
        end
        ST_COUNTING: begin
          if (empty) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
          end else if (read_accepted) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
          end else if (write_accepted) begin
            r_cnt <= '0;
          end else if (baud_clock) begin
            if (r_cnt == LAST)
              r_timeout <= 1'b1;
            else
              r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end
      endcase
    end
  end

  assign rx_timeout = r_timeout;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT receive buffer behind the UART receiver.
// Stores {framing, parity, data}; level/timeout irq, overflow.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH         = RX_DEPTH_DEF,
  parameter int AW            = RX_AW_DEF,
  parameter int IRQ_LEVEL     = RX_IRQ_DEF,
  parameter int TIMEOUT_TICKS = RX_TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          baud_clock,
  input  logic          fifo_write_n,
  input  logic [7:0]    rx_byte,
  input  logic          parity_err_in,
  input  logic          framing_err_in,
  input  logic          rd_en,
  input  logic          clear_overflow,
  output logic [7:0]    rd_data,
  output logic          rd_parity_err,
  output logic          rd_framing_err,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          rx_irq_level,
  output logic          rx_timeout
);

  rx_word_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic      w_wr_req;
  logic      w_empty;
  logic      w_full;
  logic      w_rd_acc;
  logic      w_wr_acc;
  logic      w_drop;
  rx_entry_t w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_wr_req = ~fifo_write_n;
  assign w_rd_acc = rd_en & ~w_empty;
  assign w_wr_acc = w_wr_req & (~w_full | w_rd_acc);
  assign w_drop   = w_wr_req & w_full & ~w_rd_acc;

  // Entry storage, cleared so the head reads zero after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr_acc) begin
      r_mem[r_wr_ptr] <=
        rx_pack(rx_byte, parity_err_in, framing_err_in);
    end
  end

  // Write and read pointers, wrapping modulo DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc)
        r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (w_wr_acc && !w_rd_acc)
      r_count <= r_count + 1'b1;
    else if (!w_wr_acc && w_rd_acc)
      r_count <= r_count - 1'b1;
  end

  // Sticky overflow; a drop beats a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_overflow <= 1'b0;
    else if (w_drop)
      r_overflow <= 1'b1;
    else if (clear_overflow)
      r_overflow <= 1'b0;
  end

  uart_rx_fifo_timeout #(
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_timeout (
    .clk            (clk),
    .reset_n        (reset_n),
    .baud_clock     (baud_clock),
    .empty          (w_empty),
    .write_accepted (w_wr_acc),
    .read_accepted  (w_rd_acc),
    .rx_timeout     (rx_timeout)
  );

  assign w_head         = rx_unpack(r_mem[r_rd_ptr]);
  assign rd_data        = w_head.data;
  assign rd_parity_err  = w_head.par;
  assign rd_framing_err = w_head.frm;
  assign empty          = w_empty;
  assign full           = w_full;
  assign count          = r_count;
  assign overflow       = r_overflow;
  assign rx_irq_level   = (r_count >= (AW+1)'(IRQ_LEVEL));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo.
// Hand-computed expectations for FWFT order, flags, irq, timeout.
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset_n;
  logic       baud_clock;
  logic       fifo_write_n;
  logic [7:0] rx_byte;
  logic       parity_err_in;
  logic       framing_err_in;
  logic       rd_en;
  logic       clear_overflow;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_framing_err;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       rx_irq_level;
  logic       rx_timeout;

  int n_chk;
  int n_err;

  uart_rx_fifo #(
    .DEPTH         (16),
    .AW            (4),
    .IRQ_LEVEL     (8),
    .TIMEOUT_TICKS (640)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .baud_clock     (baud_clock),
    .fifo_write_n   (fifo_write_n),
    .rx_byte        (rx_byte),
    .parity_err_in  (parity_err_in),
    .framing_err_in (framing_err_in),
    .rd_en          (rd_en),
    .clear_overflow (clear_overflow),
    .rd_data        (rd_data),
    .rd_parity_err  (rd_parity_err),
    .rd_framing_err (rd_framing_err),
    .empty          (empty),
    .full           (full),
    .count          (count),
    .overflow       (overflow),
    .rx_irq_level   (rx_irq_level),
    .rx_timeout     (rx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic push(
    input logic [7:0] b,
    input logic       p,
    input logic       f
  );
    @(negedge clk);
    fifo_write_n   = 1'b0;
    rx_byte        = b;
    parity_err_in  = p;
    framing_err_in = f;
    @(posedge clk);
    #1;
    fifo_write_n   = 1'b1;
    parity_err_in  = 1'b0;
    framing_err_in = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic push_pop(input logic [7:0] b);
    @(negedge clk);
    fifo_write_n = 1'b0;
    rx_byte      = b;
    rd_en        = 1'b1;
    @(posedge clk);
    #1;
    fifo_write_n = 1'b1;
    rd_en        = 1'b0;
  endtask

  task automatic clr_ovf();
    @(negedge clk);
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      baud_clock = 1'b1;
      @(posedge clk);
      #1;
      baud_clock = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk          = 0;
    n_err          = 0;
    reset_n        = 1'b0;
    baud_clock     = 1'b0;
    fifo_write_n   = 1'b1;
    rx_byte        = 8'h00;
    parity_err_in  = 1'b0;
    framing_err_in = 1'b0;
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
    idle(2);

    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_to", rx_timeout, 0);
    chk("rst_irq", rx_irq_level, 0);
    chk("rst_data", rd_data, 0);
    chk("rst_perr", rd_parity_err, 0);
    chk("rst_ferr", rd_framing_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);

    // order and per-entry flags
    push(8'h41, 0, 0);
    chk("w1_empty", empty, 0);
    chk("w1_data", rd_data, 8'h41);
    push(8'h42, 1, 0);
    push(8'h43, 0, 1);
    chk("w3_count", count, 3);
    chk("h41_p", rd_parity_err, 0);
    pop();
    chk("h42_d", rd_data, 8'h42);
    chk("h42_p", rd_parity_err, 1);
    chk("h42_f", rd_framing_err, 0);
    pop();
    chk("h43_d", rd_data, 8'h43);
    chk("h43_p", rd_parity_err, 0);
    chk("h43_f", rd_framing_err, 1);
    pop();
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);

    // pop on empty ignored; push+pop on empty stores
    pop();
    chk("epop_count", count, 0);
    chk("epop_empty", empty, 1);
    push_pop(8'h66);
    chk("epp_count", count, 1);
    chk("epp_data", rd_data, 8'h66);
    pop();
    chk("epp_empty", empty, 1);

    // fill, overflow, clear
    for (int i = 0; i < 16; i++)
      push(8'h10 + 8'(i), 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_ovf", overflow, 0);
    chk("fill_irq", rx_irq_level, 1);
    push(8'hFF, 0, 0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_head", rd_data, 8'h10);
    clr_ovf();
    chk("ovf_clr", overflow, 0);
    @(negedge clk);
    fifo_write_n   = 1'b0;
    rx_byte        = 8'hFE;
    clear_overflow = 1'b1;
    @(posedge clk);
    #1;
    fifo_write_n   = 1'b1;
    clear_overflow = 1'b0;
    chk("ovf_setwins", overflow, 1);
    clr_ovf();
    chk("ovf_clr2", overflow, 0);

    // push and pop while full
    push_pop(8'hA5);
    chk("fpp_count", count, 16);
    chk("fpp_ovf", overflow, 0);
    chk("fpp_full", full, 1);
    for (int i = 1; i < 16; i++) begin
      chk("fpp_seq", rd_data, 8'h10 + 8'(i));
      pop();
    end
    chk("fpp_last", rd_data, 8'hA5);
    pop();
    chk("fpp_empty", empty, 1);

    // level interrupt
    for (int i = 0; i < 7; i++)
      push(8'h30 + 8'(i), 0, 0);
    chk("irq_7", rx_irq_level, 0);
    push(8'h37, 0, 0);
    chk("irq_8", rx_irq_level, 1);
    pop();
    chk("irq_pop", rx_irq_level, 0);
    for (int i = 0; i < 7; i++)
      pop();
    chk("irq_empty", empty, 1);

    // timeout after exactly 640 ticks, cleared by pop
    push(8'h77, 0, 0);
    idle(2);
    ticks(639);
    chk("to_639", rx_timeout, 0);
    ticks(1);
    chk("to_640", rx_timeout, 1);
    ticks(5);
    chk("to_sat", rx_timeout, 1);
    pop();
    chk("to_pop", rx_timeout, 0);
    chk("to_empty", empty, 1);

    // write does not clear timeout, read does
    push(8'h78, 0, 0);
    idle(2);
    ticks(640);
    chk("to2_set", rx_timeout, 1);
    push(8'h79, 0, 0);
    chk("to2_wr", rx_timeout, 1);
    chk("to2_cnt", count, 2);
    pop();
    chk("to2_rd", rx_timeout, 0);
    pop();
    chk("to2_empty", empty, 1);

    // async reset mid-burst
    for (int i = 0; i < 5; i++)
      push(8'h50 + 8'(i), 1, 1);
    push(8'hEE, 0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("ar_empty", empty, 1);
    chk("ar_count", count, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_to", rx_timeout, 0);
    chk("ar_irq", rx_irq_level, 0);
    chk("ar_data", rd_data, 0);
    chk("ar_perr", rd_parity_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    push(8'h5A, 0, 0);
    chk("ar_w", rd_data, 8'h5A);
    chk("ar_wcnt", count, 1);
    pop();
    chk("ar_r", empty, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
